pcs_sync_fsm: RTL and testbench

Parametrised Clause-36-style code-group synchronization block for the PCS receive path. It sits between the PMA PUDI interface and the receive state machine. It acquires comma alignment after a configurable number of comma+data pairs, tracks odd/even code-group parity (rx_even), and tolerates a configurable number of bad code-groups before declaring loss of sync. It replaces the unrolled sync state chain with counter-based hysteresis and adds a registered SUDI strobe, a loss event and error statistics.

---
 rtl/pcs_pkg.sv | 34 +++
 rtl/pcs_cg_classify.sv | 23 ++
 rtl/pcs_sync_fsm.sv | 140 ++++++++++++++
 tb/tb_pcs_sync_fsm.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// rtl/pcs_pkg.sv - shared types and constants for the PCS code-group sync block
package pcs_pkg;

    typedef enum logic [2:0] {
        LOSS_OF_SYNC  = 3'd0,
        COMMA_DETECT  = 3'd1,
        ACQUIRE_SYNC  = 3'd2,
        SYNC_ACQUIRED = 3'd3
    } pcs_state_e;

    typedef enum logic [1:0] {
        CG_COMMA   = 2'd0,
        CG_DATA    = 2'd1,
        CG_INVALID = 2'd2
    } cg_class_e;

    localparam logic [9:0] K28_5_RDP = 10'b1100000101;
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;

    localparam logic OK    = 1'b1;
    localparam logic FAIL  = 1'b0;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    function automatic logic [3:0] ones10(input logic [9:0] w);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'd0, w[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/pcs_cg_classify.sv
// rtl/pcs_cg_classify.sv - combinational COMMA / DATA / INVALID classification of a code-group
module pcs_cg_classify
    import pcs_pkg::*;
(
    input  logic [9:0] cg,
    output logic       is_comma,
    output logic       is_data,
    output logic       is_invalid
);

    logic [3:0] ones;
    logic       comma_prefix;

    // Disparity-legal words (4..6 ones) that carry no stray comma prefix count as /D/.
    always_comb begin
        ones         = ones10(cg);
        comma_prefix = (cg[9:3] == 7'b1100000) || (cg[9:3] == 7'b0011111);
        is_comma     = (cg == K28_5_RDP) || (cg == K28_5_RDN);
        is_invalid   = ~is_comma && ((ones < 4'd4) || (ones > 4'd6) || comma_prefix);
        is_data      = ~is_comma && ~is_invalid;
    end

endmodule

// File: rtl/pcs_sync_fsm.sv
// rtl/pcs_sync_fsm.sv - code-group synchronization with counter-based loss hysteresis
module pcs_sync_fsm
    import pcs_pkg::*;
#(
    parameter int ACQ_COMMAS   = 3,
    parameter int LOSS_LEVELS  = 3,
    parameter int GOOD_RESTORE = 4,
    parameter int ERR_CNT_W    = 16
) (
    input  logic                 Clk,
    input  logic                 mr_main_reset_n,
    input  logic                 power_on,
    input  logic [9:0]           PUDI,
    input  logic                 PUDI_indicate,
    input  logic                 clr_err_count,
    output logic                 code_sync_status,
    output logic [10:0]          SUDI,
    output logic                 SUDI_valid,
    output logic                 sync_lost,
    output logic [2:0]           bad_level,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [2:0] ACQ_N  = 3'(ACQ_COMMAS);
    localparam logic [2:0] LOSS_N = 3'(LOSS_LEVELS);
    localparam logic [3:0] GOOD_N = 4'(GOOD_RESTORE);

    pcs_state_e state;
    logic [2:0] comma_cnt;
    logic [3:0] good_cnt;
    logic [3:0] good_nxt;
    logic       rx_even;
    logic       is_comma, is_data, is_invalid;
    logic       pos_even, cgbad, tag;

    pcs_cg_classify u_classify (
        .cg         (PUDI),
        .is_comma   (is_comma),
        .is_data    (is_data),
        .is_invalid (is_invalid)
    );

    assign pos_even = ~rx_even;
    assign cgbad    = is_invalid | (is_comma & ~pos_even);
    assign good_nxt = good_cnt + 4'd1;
    // A comma seen while hunting for alignment defines the even position.
    assign tag      = (is_comma && (state == LOSS_OF_SYNC ||
                                    (state == ACQUIRE_SYNC && pos_even))) ? TRUE : pos_even;

    always_ff @(posedge Clk) begin
        if (!mr_main_reset_n || power_on) begin
            state            <= LOSS_OF_SYNC;
            code_sync_status <= FAIL;
            SUDI             <= '0;
            SUDI_valid       <= 1'b0;
            sync_lost        <= 1'b0;
            bad_level        <= '0;
            err_count        <= '0;
            comma_cnt        <= '0;
            good_cnt         <= '0;
            rx_even          <= 1'b0;
        end else begin
            SUDI_valid <= 1'b0;
            sync_lost  <= 1'b0;
            if (PUDI_indicate) begin
                SUDI       <= {PUDI, tag};
                SUDI_valid <= 1'b1;
                rx_even    <= tag;
                case (state)
                    LOSS_OF_SYNC: begin
                        code_sync_status <= FAIL;
                        if (is_comma) begin
                            state     <= COMMA_DETECT;
                            comma_cnt <= 3'd1;
                        end
                    end
                    COMMA_DETECT: begin
                        if (is_data && comma_cnt == ACQ_N) begin
                            state            <= SYNC_ACQUIRED;
                            code_sync_status <= OK;
                            bad_level        <= '0;
                            good_cnt         <= '0;
                        end else if (is_data) begin
                            state <= ACQUIRE_SYNC;
                        end else begin
                            state     <= LOSS_OF_SYNC;
                            comma_cnt <= '0;
                        end
                    end
                    ACQUIRE_SYNC: begin
                        if (is_comma && pos_even) begin
                            state     <= COMMA_DETECT;
                            comma_cnt <= comma_cnt + 3'd1;
                        end else if (cgbad) begin
                            state     <= LOSS_OF_SYNC;
                            comma_cnt <= '0;
                        end
                    end
                    SYNC_ACQUIRED: begin
                        if (cgbad) begin
                            if (err_count != {ERR_CNT_W{1'b1}}) begin
                                err_count <= err_count + 1'b1;
                            end
                            good_cnt <= '0;
                            if (bad_level == LOSS_N) begin
                                state            <= LOSS_OF_SYNC;
                                code_sync_status <= FAIL;
                                sync_lost        <= 1'b1;
                                bad_level        <= '0;
                                comma_cnt        <= '0;
                            end else begin
                                bad_level <= bad_level + 3'd1;
                            end
                        end else if (bad_level != 3'd0) begin
                            if (good_nxt == GOOD_N) begin
                                bad_level <= bad_level - 3'd1;
                                good_cnt  <= '0;
                            end else begin
                                good_cnt <= good_nxt;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end
                    default: begin
                        state            <= LOSS_OF_SYNC;
                        code_sync_status <= FAIL;
                        comma_cnt        <= '0;
                        bad_level        <= '0;
                        good_cnt         <= '0;
                    end
                endcase
            end
            if (clr_err_count) begin
                err_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pcs_sync_fsm.sv
// tb/tb_pcs_sync_fsm.sv - directed self-checking bench for pcs_sync_fsm
module tb_pcs_sync_fsm;

    localparam logic [9:0] KP  = 10'b1100000101;
    localparam logic [9:0] DD  = 10'b0110110101;
    localparam logic [9:0] INV = 10'b0000000000;

    logic        Clk = 1'b0;
    logic        mr_main_reset_n;
    logic        power_on;
    logic [9:0]  PUDI;
    logic        PUDI_indicate;
    logic        clr_err_count;

    logic        status_a, valid_a, lost_a;
    logic [10:0] sudi_a;
    logic [2:0]  bad_a;
    logic [15:0] err_a;

    logic        status_b, valid_b, lost_b;
    logic [10:0] sudi_b;
    logic [2:0]  bad_b;
    logic [3:0]  err_b;

    int total = 0;
    int bad   = 0;

    pcs_sync_fsm dut_a (
        .Clk              (Clk),
        .mr_main_reset_n  (mr_main_reset_n),
        .power_on         (power_on),
        .PUDI             (PUDI),
        .PUDI_indicate    (PUDI_indicate),
        .clr_err_count    (clr_err_count),
        .code_sync_status (status_a),
        .SUDI             (sudi_a),
        .SUDI_valid       (valid_a),
        .sync_lost        (lost_a),
        .bad_level        (bad_a),
        .err_count        (err_a)
    );

    pcs_sync_fsm #(.ERR_CNT_W(4)) dut_b (
        .Clk              (Clk),
        .mr_main_reset_n  (mr_main_reset_n),
        .power_on         (power_on),
        .PUDI             (PUDI),
        .PUDI_indicate    (PUDI_indicate),
        .clr_err_count    (clr_err_count),
        .code_sync_status (status_b),
        .SUDI             (sudi_b),
        .SUDI_valid       (valid_b),
        .sync_lost        (lost_b),
        .bad_level        (bad_b),
        .err_count        (err_b)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [9:0] cg);
        PUDI          = cg;
        PUDI_indicate = 1'b1;
        @(posedge Clk);
        #1;
        PUDI_indicate = 1'b0;
        clr_err_count = 1'b0;
    endtask

    task automatic idle();
        PUDI_indicate = 1'b0;
        @(posedge Clk);
        #1;
        clr_err_count = 1'b0;
    endtask

    task automatic acquire(input string tag);
        for (int i = 0; i < 3; i++) begin
            send(KP);
            send(DD);
        end
        chk({tag, "_status"}, status_a, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_status"}, status_a, 0);
        chk({tag, "_sudi"}, sudi_a, 0);
        chk({tag, "_valid"}, valid_a, 0);
        chk({tag, "_lost"}, lost_a, 0);
        chk({tag, "_bad"}, bad_a, 0);
        chk({tag, "_err"}, err_a, 0);
    endtask

    initial begin
        mr_main_reset_n = 1'b0;
        power_on        = 1'b0;
        PUDI            = '0;
        PUDI_indicate   = 1'b0;
        clr_err_count   = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk_reset("reset");
        mr_main_reset_n = 1'b1;

        // acquisition: K D K D K D, status rises only after the sixth
        for (int i = 0; i < 6; i++) begin
            send((i % 2 == 0) ? KP : DD);
            chk($sformatf("acq_tag%0d", i), sudi_a[0], (i % 2 == 0) ? 1 : 0);
            chk($sformatf("acq_valid%0d", i), valid_a, 1);
            chk($sformatf("acq_status%0d", i), status_a, (i == 5) ? 1 : 0);
        end
        chk("acq_data", sudi_a[10:1], DD);
        chk("acq_bad", bad_a, 0);

        // loss hysteresis: 4 invalids
        for (int i = 1; i <= 3; i++) begin
            send(INV);
            chk($sformatf("loss_bad%0d", i), bad_a, i);
            chk($sformatf("loss_nolost%0d", i), lost_a, 0);
            chk($sformatf("loss_status%0d", i), status_a, 1);
        end
        send(INV);
        chk("loss_lost", lost_a, 1);
        chk("loss_status", status_a, 0);
        chk("loss_bad0", bad_a, 0);
        chk("loss_err", err_a, 4);
        idle();
        chk("loss_pulse", lost_a, 0);

        // recovery: one invalid then four good code-groups
        acquire("reacq1");
        send(KP);
        send(INV);
        chk("rec_bad1", bad_a, 1);
        chk("rec_err", err_a, 5);
        send(KP);
        chk("rec_hold1", bad_a, 1);
        send(DD);
        chk("rec_hold2", bad_a, 1);
        send(KP);
        chk("rec_hold3", bad_a, 1);
        send(DD);
        chk("rec_bad0", bad_a, 0);
        chk("rec_status", status_a, 1);
        chk("rec_nolost", lost_a, 0);

        // misaligned comma while in sync
        send(DD);
        send(KP);
        chk("mis_tag", sudi_a[0], 0);
        chk("mis_bad", bad_a, 1);
        chk("mis_err", err_a, 6);
        chk("mis_status", status_a, 1);
        send(KP); send(DD); send(KP); send(DD);
        chk("mis_rec", bad_a, 0);

        // gaps freeze everything
        send(KP);
        chk("gap_v1", valid_a, 1);
        PUDI = INV;
        idle();
        chk("gap_v0", valid_a, 0);
        chk("gap_sudi", sudi_a, {KP, 1'b1});
        chk("gap_bad", bad_a, 0);
        chk("gap_err", err_a, 6);
        send(DD);
        chk("gap_v2", valid_a, 1);
        chk("gap_sudi2", sudi_a, {DD, 1'b0});

        // clear coincident with a bad code-group
        clr_err_count = 1'b1;
        send(INV);
        chk("clr_err", err_a, 0);
        chk("clr_bad", bad_a, 1);
        send(DD); send(KP); send(DD); send(KP);
        chk("clr_rec", bad_a, 0);
        send(DD);

        // mid-sync reset and power_on
        send(INV);
        mr_main_reset_n = 1'b0;
        idle();
        mr_main_reset_n = 1'b1;
        chk_reset("mrst");
        acquire("reacq2");
        send(INV);
        power_on = 1'b1;
        send(KP);
        power_on = 1'b0;
        chk_reset("pwr");

        // misaligned comma in ACQUIRE_SYNC drops back to LOSS_OF_SYNC
        send(KP); send(DD); send(DD);
        send(KP);
        chk("acqmis_tag", sudi_a[0], 0);
        send(KP); send(DD); send(KP); send(DD);
        chk("acqmis_nosync", status_a, 0);
        send(KP); send(DD);
        chk("acqmis_sync", status_a, 1);

        // saturation of the narrow counter
        clr_err_count = 1'b1;
        idle();
        chk("sat_clr", err_b, 0);
        for (int i = 0; i < 20; i++) begin
            send(KP); send(INV);
            send(KP); send(DD); send(KP); send(DD);
        end
        chk("sat_b", err_b, 15);
        chk("sat_a", err_a, 20);
        chk("sat_bad", bad_b, 0);
        chk("sat_status", status_b, 1);
        send(KP);
        clr_err_count = 1'b1;
        send(INV);
        chk("sat_clr_b", err_b, 0);
        chk("sat_clr_a", err_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
